// File: rtl/uart_frame_pkg.sv
// Shared types for the UART receive frame controller.
//   frame_state_t : controller states (HUNT, LEN, PAYLOAD, CHECK, HOLD)
//   err_code_t    : abort cause reported on o_err_code
//   SYNC_DEFAULT  : default frame start marker
package uart_frame_pkg;

  typedef enum logic [2:0] {
    ST_HUNT    = 3'd0,
    ST_LEN     = 3'd1,
    ST_PAYLOAD = 3'd2,
    ST_CHECK   = 3'd3,
    ST_HOLD    = 3'd4
  } frame_state_t;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_BAD_LEN = 2'd1,
    ERR_BAD_CHK = 2'd2,
    ERR_TIMEOUT = 2'd3
  } err_code_t;

  localparam logic [7:0] SYNC_DEFAULT = 8'hA5;

endpackage

// File: rtl/uart_rx_frame_buf.sv
// Payload buffer for the frame controller.
//   clock : write clock
//   we    : write enable
//   waddr : write index
//   wdata : byte to store
//   raddr : read index (asynchronous read)
//   rdata : byte at raddr
// No reset: contents are only meaningful once a frame has been written.
module uart_rx_frame_buf #(
  parameter int MAX_PAYLOAD = 16,
  parameter int AW          = $clog2(MAX_PAYLOAD)
) (
  input  logic          clock,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  logic [7:0] mem [MAX_PAYLOAD];

  always_ff @(posedge clock) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// Frame controller behind the UART receiver. Hunts for SYNC, takes LEN and
// LEN payload bytes into a local buffer, verifies the XOR checksum and holds
// the frame for the command decoder until acknowledged.
//   i_clock, i_reset  : clock, synchronous active-high reset
//   i_data_available  : one-cycle strobe per received byte
//   i_data_byte       : received byte
//   i_frame_ack       : consumer releases the held frame
//   i_rd_addr         : payload read index
//   o_rd_data         : payload byte at i_rd_addr (combinational)
//   o_frame_valid     : checked frame held
//   o_frame_len       : LEN of the held frame
//   o_error           : one-cycle pulse on frame abort
//   o_err_code        : cause of the last abort
//   o_overrun         : one-cycle pulse when a byte is dropped in HOLD
module uart_rx_frame_ctrl
  import uart_frame_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE    = SYNC_DEFAULT,
  parameter int         MAX_PAYLOAD  = 16,
  parameter int         TIMEOUT_CLKS = 50000
) (
  input  logic                           i_clock,
  input  logic                           i_reset,
  input  logic                           i_data_available,
  input  logic [7:0]                     i_data_byte,
  input  logic                           i_frame_ack,
  input  logic [$clog2(MAX_PAYLOAD)-1:0] i_rd_addr,
  output logic [7:0]                     o_rd_data,
  output logic                           o_frame_valid,
  output logic [7:0]                     o_frame_len,
  output logic                           o_error,
  output logic [1:0]                     o_err_code,
  output logic                           o_overrun
);

  localparam int         AW       = $clog2(MAX_PAYLOAD);
  localparam int         IW       = $clog2(TIMEOUT_CLKS);
  localparam logic [7:0] MAX_LEN  = 8'(MAX_PAYLOAD);
  localparam logic [IW-1:0] IDLE_MAX = IW'(TIMEOUT_CLKS - 1);

  frame_state_t  state, state_n;
  logic [7:0]    len_q, len_n;
  logic [7:0]    chk_q, chk_n;
  logic [AW-1:0] idx_q, idx_n;
  logic [IW-1:0] idle_q, idle_n;
  logic [7:0]    frame_len_n;
  logic          error_n;
  logic          overrun_n;
  err_code_t     err_code_q, err_code_n;
  logic          buf_we;

  function automatic logic len_ok(input logic [7:0] len);
    return (len != 8'd0) && (len <= MAX_LEN);
  endfunction

  uart_rx_frame_buf #(
    .MAX_PAYLOAD(MAX_PAYLOAD),
    .AW         (AW)
  ) u_buf (
    .clock(i_clock),
    .we   (buf_we),
    .waddr(idx_q),
    .wdata(i_data_byte),
    .raddr(i_rd_addr),
    .rdata(o_rd_data)
  );

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state         <= ST_HUNT;
      len_q         <= '0;
      chk_q         <= '0;
      idx_q         <= '0;
      idle_q        <= '0;
      o_frame_valid <= 1'b0;
      o_frame_len   <= '0;
      o_error       <= 1'b0;
      err_code_q    <= ERR_NONE;
      o_overrun     <= 1'b0;
    end else begin
      state         <= state_n;
      len_q         <= len_n;
      chk_q         <= chk_n;
      idx_q         <= idx_n;
      idle_q        <= idle_n;
      o_frame_valid <= (state_n == ST_HOLD);
      o_frame_len   <= frame_len_n;
      o_error       <= error_n;
      err_code_q    <= err_code_n;
      o_overrun     <= overrun_n;
    end
  end

  assign o_err_code = err_code_q;

  always_comb begin
    state_n     = state;
    len_n       = len_q;
    chk_n       = chk_q;
    idx_n       = idx_q;
    idle_n      = idle_q;
    frame_len_n = o_frame_len;
    error_n     = 1'b0;
    err_code_n  = err_code_q;
    overrun_n   = 1'b0;
    buf_we      = 1'b0;

    unique case (state)
      ST_HUNT: begin
        // Idle counter is held at zero so every frame starts a fresh window.
        idle_n = '0;
        if (i_data_available && (i_data_byte == SYNC_BYTE)) begin
          state_n = ST_LEN;
        end
      end
      ST_LEN: begin
        if (i_data_available) begin
          idle_n = '0;
          if (len_ok(i_data_byte)) begin
            len_n   = i_data_byte;
            chk_n   = i_data_byte;
            idx_n   = '0;
            state_n = ST_PAYLOAD;
          end else begin
            error_n    = 1'b1;
            err_code_n = ERR_BAD_LEN;
            state_n    = ST_HUNT;
          end
        end
      end
      ST_PAYLOAD: begin
        if (i_data_available) begin
          idle_n = '0;
          buf_we = 1'b1;
          chk_n  = chk_q ^ i_data_byte;
          idx_n  = idx_q + AW'(1);
          if (8'(idx_q) == (len_q - 8'd1)) begin
            state_n = ST_CHECK;
          end
        end
      end
      ST_CHECK: begin
        if (i_data_available) begin
          idle_n = '0;
          if (i_data_byte == chk_q) begin
            frame_len_n = len_q;
            state_n     = ST_HOLD;
          end else begin
            error_n    = 1'b1;
            err_code_n = ERR_BAD_CHK;
            state_n    = ST_HUNT;
          end
        end
      end
      ST_HOLD: begin
        // Every byte arriving while a frame is held is lost, even on the ack cycle.
        overrun_n = i_data_available;
        if (i_frame_ack) begin
          state_n = ST_HUNT;
        end
      end
      default: begin
        state_n = ST_HUNT;
      end
    endcase

    // Inter-byte timeout inside a frame; a strobe in the same cycle takes priority.
    if (!i_data_available &&
        ((state == ST_LEN) || (state == ST_PAYLOAD) || (state == ST_CHECK))) begin
      if (idle_q == IDLE_MAX) begin
        error_n    = 1'b1;
        err_code_n = ERR_TIMEOUT;
        state_n    = ST_HUNT;
        idle_n     = '0;
      end else begin
        idle_n = idle_q + IW'(1);
      end
    end
  end

endmodule
